// File: rtl/zrb_uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encodings and the header tag.
package zrb_uart_tx_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR     = 3'd1,
        S_FETCH   = 3'd2,
        S_SEND    = 3'd3,
        S_WAIT_HI = 3'd4,
        S_WAIT_LO = 3'd5
    } state_t;

    // Upper nibble of the per-packet header byte; the lower nibble carries the requester index.
    localparam logic [3:0] HDR_TAG = 4'hA;

endpackage

// File: rtl/zrb_uart_tx_scheduler_if.sv
// Requester-side byte streams plus the zrb_uart_tx write/busy pair, bundled for the scheduler.
interface zrb_uart_tx_scheduler_if #(
    parameter int NUM_REQ = 4
);
    // Requester i hands over req_data[i*8+:8] on the cycle where req_valid[i] & req_ready[i];
    // valid may rise or fall freely, data/last must be stable while valid is high.
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   grant;
    logic                 uart_write;
    logic [7:0]           uart_data;
    logic                 uart_busy;
    logic                 timeout;

    modport master (
        input  req_valid, req_data, req_last, uart_busy,
        output req_ready, grant, uart_write, uart_data, timeout
    );

    modport slave (
        output req_valid, req_data, req_last, uart_busy,
        input  req_ready, grant, uart_write, uart_data, timeout
    );

endinterface

// File: rtl/zrb_uart_tx_scheduler_arbiter.sv
// Combinational round-robin pick: first requester after ptr (wrapping) wins.
module zrb_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);
    logic found;
    int   cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        // Scanning offsets 1..N from the pointer gives the pointer itself lowest priority.
        for (int k = 1; k <= N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/zrb_uart_tx_scheduler.sv
// Packet-granular round-robin scheduler feeding one zrb_uart_tx from NUM_REQ byte streams.
// Optional per-packet header byte: define ZRB_UART_TX_CH_HEADER_EN.
module zrb_uart_tx_scheduler
    import zrb_uart_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int LOCK_TIMEOUT = 255,
    parameter int CNT_W        = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    zrb_uart_tx_scheduler_if.master bus,
    output state_t                  dbg_state
);
    localparam int IW = $clog2(NUM_REQ);

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] grant_r;
    logic [IW-1:0]      g_idx;
    logic [IW-1:0]      ptr;
    logic [7:0]         uart_data_r;
    logic               last_r;
    logic [CNT_W-1:0]   tmo_cnt;
    logic               timeout_r;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IW-1:0]      arb_idx;

    logic do_grant, do_xfer, idle_tick, tmo_hit, rel_last;
`ifdef ZRB_UART_TX_CH_HEADER_EN
    logic hdr_r, hdr_load, hdr_done;
`endif

    zrb_rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
        .req (bus.req_valid),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    always_comb begin
        state_nxt = state;
        do_grant  = 1'b0;
        do_xfer   = 1'b0;
        idle_tick = 1'b0;
        tmo_hit   = 1'b0;
        rel_last  = 1'b0;
`ifdef ZRB_UART_TX_CH_HEADER_EN
        hdr_load  = 1'b0;
        hdr_done  = 1'b0;
`endif
        unique case (state)
            S_IDLE: begin
                if (!bus.uart_busy && (|bus.req_valid)) begin
                    do_grant = 1'b1;
`ifdef ZRB_UART_TX_CH_HEADER_EN
                    state_nxt = S_HDR;
`else
                    state_nxt = S_FETCH;
`endif
                end
            end
`ifdef ZRB_UART_TX_CH_HEADER_EN
            S_HDR: begin
                hdr_load  = 1'b1;
                state_nxt = S_SEND;
            end
`endif
            S_FETCH: begin
                if (bus.req_valid[g_idx]) begin
                    do_xfer   = 1'b1;
                    state_nxt = S_SEND;
                end else if (tmo_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    // This is the LOCK_TIMEOUT-th idle cycle: give the channel up.
                    tmo_hit   = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    idle_tick = 1'b1;
                end
            end
            S_SEND:    state_nxt = S_WAIT_HI;
            S_WAIT_HI: if (bus.uart_busy) state_nxt = S_WAIT_LO;
            S_WAIT_LO: begin
                if (!bus.uart_busy) begin
`ifdef ZRB_UART_TX_CH_HEADER_EN
                    if (hdr_r) begin
                        hdr_done  = 1'b1;
                        state_nxt = S_FETCH;
                    end else
`endif
                    if (last_r) begin
                        rel_last  = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_FETCH;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_r     <= '0;
            g_idx       <= '0;
            ptr         <= IW'(NUM_REQ - 1);
            uart_data_r <= 8'h00;
            last_r      <= 1'b0;
            tmo_cnt     <= '0;
            timeout_r   <= 1'b0;
`ifdef ZRB_UART_TX_CH_HEADER_EN
            hdr_r       <= 1'b0;
`endif
        end else begin
            timeout_r <= tmo_hit;
            if (do_grant) begin
                grant_r <= arb_gnt;
                g_idx   <= arb_idx;
                tmo_cnt <= '0;
            end
`ifdef ZRB_UART_TX_CH_HEADER_EN
            if (hdr_load) begin
                uart_data_r <= {HDR_TAG, 4'(g_idx)};
                hdr_r       <= 1'b1;
            end
            if (hdr_done) hdr_r <= 1'b0;
`endif
            if (do_xfer) begin
                uart_data_r <= bus.req_data[{g_idx, 3'b000} +: 8];
                last_r      <= bus.req_last[g_idx];
                tmo_cnt     <= '0;
            end
            if (idle_tick) tmo_cnt <= tmo_cnt + 1'b1;
            // Released owner becomes the pointer, so it ranks last in the next round.
            if (tmo_hit || rel_last) begin
                grant_r <= '0;
                ptr     <= g_idx;
                tmo_cnt <= '0;
            end
        end
    end

    assign bus.req_ready  = (state == S_FETCH) ? (grant_r & bus.req_valid) : '0;
    assign bus.grant      = grant_r;
    assign bus.uart_write = (state == S_SEND);
    assign bus.uart_data  = uart_data_r;
    assign bus.timeout    = timeout_r;
    assign dbg_state      = state;

endmodule

// File: tb/tb_zrb_uart_tx_scheduler.sv
// Directed bench for zrb_uart_tx_scheduler with a behavioural UART busy model and byte scoreboard.
module tb_zrb_uart_tx_scheduler;
    import zrb_uart_tx_scheduler_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int FRAME   = 4;

    logic   clk = 1'b0;
    logic   reset = 1'b1;
    state_t dbg_state;

    zrb_uart_tx_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

    zrb_uart_tx_scheduler #(.NUM_REQ(NUM_REQ), .LOCK_TIMEOUT(255), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- counters / scoreboard ----------------
    int total = 0;
    int bad = 0;
    int ready_cnt = 0;
    logic [7:0] exp_q[$];
    logic [8:0] exp_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- requester model (per-requester byte rings) ----------------
    logic [8:0]         rq_mem [NUM_REQ][16];
    int                 rq_wr [NUM_REQ];
    int                 rq_rd [NUM_REQ];
    logic [NUM_REQ-1:0] xfer_s = '0;

    always_comb begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_valid[i]      = (rq_rd[i] != rq_wr[i]);
            bus.req_data[i*8 +: 8] = rq_mem[i][rq_rd[i]][7:0];
            bus.req_last[i]       = rq_mem[i][rq_rd[i]][8];
        end
    end

    task automatic push(input int i, input logic [7:0] d, input logic last);
        rq_mem[i][rq_wr[i]] = {last, d};
        rq_wr[i] = (rq_wr[i] + 1) % 16;
    endtask

    task automatic exp_pkt(input int g);
`ifdef ZRB_UART_TX_CH_HEADER_EN
        logic [3:0] gn;
        gn = 4'(g);
        exp_q.push_back({4'hA, gn});
`else
        if (g < 0) exp_q.push_back(8'h00);
`endif
    endtask

    function automatic bit rq_all_empty();
        bit e;
        e = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) if (rq_rd[i] != rq_wr[i]) e = 1'b0;
        return e;
    endfunction

    // ---------------- UART model: busy rises one cycle after write ----------------
    logic wr_s = 1'b0;
    int   busy_cnt = 0;
    logic force_busy = 1'b0;
    assign bus.uart_busy = force_busy || (busy_cnt != 0);

    always @(negedge clk) begin
        wr_s   = bus.uart_write;
        xfer_s = bus.req_valid & bus.req_ready;
    end

    always @(posedge clk) begin
        if (wr_s) busy_cnt <= FRAME;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        for (int i = 0; i < NUM_REQ; i++)
            if (xfer_s[i]) rq_rd[i] <= (rq_rd[i] + 1) % 16;
    end

    // ---------------- continuous monitor ----------------
    always @(negedge clk) begin
        if (bus.uart_write) begin
            if (exp_q.size() != 0) exp_b = {1'b0, exp_q.pop_front()};
            else exp_b = 9'h1FF;
            chk("uart_byte", {24'b0, bus.uart_data}, {23'b0, exp_b});
        end
        chk("write_while_busy", {31'b0, bus.uart_write & bus.uart_busy}, 32'd0);
        chk("ready_rules", {31'b0, $onehot0(bus.req_ready) && ((bus.req_ready & ~bus.grant) == '0)
                               && (dbg_state == S_FETCH || bus.req_ready == '0)}, 32'd1);
        if (bus.req_ready != '0) ready_cnt++;
    end

    task automatic wait_idle(input string tag);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        while (n < 300 && !done) begin
            tick(1);
            n++;
            done = (dbg_state == S_IDLE) && !bus.uart_busy && (exp_q.size() == 0) && rq_all_empty();
        end
        chk({tag, "_drain"}, {31'b0, done}, 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_grant"}, {28'b0, bus.grant}, 32'd0);
        chk({tag, "_ready"}, {28'b0, bus.req_ready}, 32'd0);
        chk({tag, "_write"}, {31'b0, bus.uart_write}, 32'd0);
        chk({tag, "_data"}, {24'b0, bus.uart_data}, 32'd0);
        chk({tag, "_timeout"}, {31'b0, bus.timeout}, 32'd0);
        chk({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
    endtask

    // ---------------- directed sequence ----------------
    int fetch_idle;
    bit got_tmo;
    bit seen_wlo;

    initial begin
        for (int i = 0; i < NUM_REQ; i++)
            for (int j = 0; j < 16; j++) rq_mem[i][j] = '0;

        reset = 1'b1;
        tick(3);
        chk_reset_outputs("rst");
        reset = 1'b0;

        // 1: single requester, single-byte packet
        push(0, 8'h55, 1'b1);
        exp_pkt(0); exp_q.push_back(8'h55);
        tick(1);
        chk("t1_grant", {28'b0, bus.grant}, 32'h1);
`ifndef ZRB_UART_TX_CH_HEADER_EN
        chk("t1_ready", {28'b0, bus.req_ready}, 32'h1);
        tick(1);
        chk("t1_write", {31'b0, bus.uart_write}, 32'd1);
        chk("t1_data", {24'b0, bus.uart_data}, 32'h55);
`endif
        wait_idle("t1");
        chk("t1_release", {28'b0, bus.grant}, 32'd0);

        // 2: all four valid, served 0..3, then req0 first again
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) push(i, 8'h10 + 8'(i), 1'b1);
        for (int i = 0; i < NUM_REQ; i++) begin exp_pkt(i); exp_q.push_back(8'h10 + 8'(i)); end
        wait_idle("t2a");
        push(1, 8'h21, 1'b1);
        push(0, 8'h20, 1'b1);
        exp_pkt(0); exp_q.push_back(8'h20);
        exp_pkt(1); exp_q.push_back(8'h21);
        tick(1);
        chk("t2_wrap_grant", {28'b0, bus.grant}, 32'h1);
        wait_idle("t2b");

        // 3: multi-byte packet is not interleaved with a waiting requester
        do_reset();
        push(1, 8'hA1, 1'b0); push(1, 8'hA2, 1'b0); push(1, 8'hA3, 1'b1);
        push(2, 8'hB1, 1'b1);
        exp_pkt(1); exp_q.push_back(8'hA1); exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
        exp_pkt(2); exp_q.push_back(8'hB1);
        tick(1);
        chk("t3_grant", {28'b0, bus.grant}, 32'h2);
        tick(12);
        chk("t3_hold", {28'b0, bus.grant}, 32'h2);
        wait_idle("t3");
        chk("t3_release", {28'b0, bus.grant}, 32'd0);

        // 4: granted requester goes silent mid-packet -> lock timeout
        do_reset();
        push(3, 8'hD1, 1'b0);
        exp_pkt(3); exp_q.push_back(8'hD1);
        tick(1);
        chk("t4_grant", {28'b0, bus.grant}, 32'h8);
        push(0, 8'hE0, 1'b1);
        exp_pkt(0); exp_q.push_back(8'hE0);
        fetch_idle = 0;
        got_tmo = 1'b0;
        for (int n = 0; n < 400 && !got_tmo; n++) begin
            tick(1);
            if (bus.timeout) got_tmo = 1'b1;
            else if (dbg_state == S_FETCH && !bus.req_valid[3]) fetch_idle++;
        end
        chk("t4_timeout_seen", {31'b0, got_tmo}, 32'd1);
        chk("t4_idle_cycles", fetch_idle, 32'd255);
        chk("t4_grant_cleared", {28'b0, bus.grant}, 32'd0);
        chk("t4_state", 32'(dbg_state), 32'(S_IDLE));
        tick(1);
        chk("t4_pulse_width", {31'b0, bus.timeout}, 32'd0);
        chk("t4_next_grant", {28'b0, bus.grant}, 32'h1);
        wait_idle("t4");

        // 5: external busy held high at arbitration
        force_busy = 1'b1;
        push(1, 8'h5A, 1'b1);
        exp_pkt(1); exp_q.push_back(8'h5A);
        tick(10);
        chk("t5_no_grant", {28'b0, bus.grant}, 32'd0);
        chk("t5_state", 32'(dbg_state), 32'(S_IDLE));
        chk("t5_no_write", {31'b0, bus.uart_write}, 32'd0);
        force_busy = 1'b0;
        wait_idle("t5");

        // 6: one req_ready pulse per byte, then reset during WAIT_LO
        do_reset();
        ready_cnt = 0;
        push(2, 8'hC3, 1'b1);
        exp_pkt(2); exp_q.push_back(8'hC3);
        wait_idle("t6a");
        chk("t6_ready_pulses", ready_cnt, 32'd1);
        push(2, 8'hC4, 1'b1);
        exp_pkt(2); exp_q.push_back(8'hC4);
        seen_wlo = 1'b0;
        for (int n = 0; n < 50 && !seen_wlo; n++) begin
            tick(1);
            if (dbg_state == S_WAIT_LO) seen_wlo = 1'b1;
        end
        chk("t6_reached_wait_lo", {31'b0, seen_wlo}, 32'd1);
        reset = 1'b1;
        tick(1);
        chk_reset_outputs("t6_rst");
        reset = 1'b0;
        exp_q.delete();
        for (int i = 0; i < NUM_REQ; i++) rq_wr[i] = rq_rd[i];
        tick(2);
        chk("t6_post_grant", {28'b0, bus.grant}, 32'd0);
        wait_idle("t6b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
